// File: rtl/ttt_game_ctrl_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Board squares: rows 8 7 6 / 5 4 3 / 2 1 0.
package ttt_game_ctrl_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    WIN_A = 2'b01,
    WIN_B = 2'b10,
    DRAW  = 2'b11
  } game_state_e;

  localparam logic [8:0] FULL_BOARD = 9'h1FF;

  localparam int unsigned WL_ROW876  = 0;
  localparam int unsigned WL_ROW543  = 1;
  localparam int unsigned WL_ROW210  = 2;
  localparam int unsigned WL_COL852  = 3;
  localparam int unsigned WL_COL741  = 4;
  localparam int unsigned WL_COL630  = 5;
  localparam int unsigned WL_DIAG840 = 6;
  localparam int unsigned WL_DIAG246 = 7;

  function automatic logic [8:0] line_mask(
    input int unsigned idx
  );
    logic [8:0] m;
    m = '0;
    case (idx)
      WL_ROW876:  m = 9'h1C0;
      WL_ROW543:  m = 9'h038;
      WL_ROW210:  m = 9'h007;
      WL_COL852:  m = 9'h124;
      WL_COL741:  m = 9'h092;
      WL_COL630:  m = 9'h049;
      WL_DIAG840: m = 9'h111;
      WL_DIAG246: m = 9'h054;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_line_win_detect.sv
// Combinational detector: flags every line fully held
// by either player on the supplied boards.
module line_win_detect
  import ttt_game_ctrl_pkg::*;
(
  input  logic [8:0] a_nxt,
  input  logic [8:0] b_nxt,
  output logic [7:0] lines
);

  for (genvar i = 0; i < 8; i++) begin : g_line
    localparam logic [8:0] M = line_mask(i);
    assign lines[i] = ((a_nxt & M) == M) ||
                      ((b_nxt & M) == M);
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: move legality, board
// registers, win/draw evaluation and turn tracking.
module ttt_game_ctrl
  import ttt_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [8:0] move_pos,
  output logic [8:0] ain,
  output logic [8:0] bin,
  output logic       turn,
  output logic [1:0] game_state,
  output logic [7:0] win_line,
  output logic [3:0] move_count,
  output logic       move_ack,
  output logic       move_err
);

  game_state_e state_q, state_d;
  logic [8:0]  a_q, a_d, b_q, b_d;
  logic        turn_q, turn_d;
  logic        first_q, first_d;
  logic [7:0]  wl_q, wl_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic        pos_onehot;
  logic        legal;
  logic [8:0]  a_nxt, b_nxt;
  logic [7:0]  lines;

  assign pos_onehot = (move_pos != '0) &&
    ((move_pos & (move_pos - 9'd1)) == '0);
  assign legal = (state_q == PLAY) && pos_onehot &&
    ((move_pos & (a_q | b_q)) == '0);

  // Candidate boards if this request is accepted.
  assign a_nxt = a_q |
    ((legal && !turn_q) ? move_pos : 9'h000);
  assign b_nxt = b_q |
    ((legal && turn_q) ? move_pos : 9'h000);

  line_win_detect u_detect (
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .lines (lines)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PLAY;
      a_q     <= '0;
      b_q     <= '0;
      turn_q  <= 1'b0;
      first_q <= 1'b0;
      wl_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      turn_q  <= turn_d;
      first_q <= first_d;
      wl_q    <= wl_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    turn_d  = turn_q;
    first_d = first_q;
    wl_d    = wl_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    if (new_game) begin
      state_d = PLAY;
      a_d     = '0;
      b_d     = '0;
      wl_d    = '0;
      cnt_d   = '0;
      first_d = ~first_q;
      turn_d  = ~first_q;
    end else if (move_valid) begin
      if (legal) begin
        a_d    = a_nxt;
        b_d    = b_nxt;
        turn_d = ~turn_q;
        cnt_d  = cnt_q + 4'd1;
        ack_d  = 1'b1;
        // A completed line outranks a full board.
        if (|lines) begin
          state_d = turn_q ? WIN_B : WIN_A;
          wl_d    = lines;
        end else if ((a_nxt | b_nxt) == FULL_BOARD) begin
          state_d = DRAW;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    ain        = a_q;
    bin        = b_q;
    turn       = turn_q;
    game_state = state_q;
    win_line   = wl_q;
    move_count = cnt_q;
    move_ack   = ack_q;
    move_err   = err_q;
  end

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Sequential tic-tac-toe game controller. It accepts one-hot move requests on behalf of the player to move and keeps the registered board vectors `ain`/`bin`. It detects wins and draws on the board that results from each accepted move, and publishes game state, the winning line and turn information. It owns the board state that the win-line detector consumes, and sits between the player/move-entry logic and the display logic.

## Interface
- No parameters (board fixed at 3x3, 9 squares).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `new_game`  in  1  pulse; clears the board and starts the next game.
- `move_valid`  in  1  move request strobe, sampled every cycle.
- `move_pos`  in  9  requested square, one-hot, bit i = square i. Rows are 8 7 6 / 5 4 3 / 2 1 0.
- `ain`  out  9  squares held by player A (registered).
- `bin`  out  9  squares held by player B (registered).
- `turn`  out  1  player to move: 0 = A, 1 = B.
- `game_state`  out  2  00 PLAY, 01 WIN_A, 10 WIN_B, 11 DRAW.
- `win_line`  out  8  one-hot winning line, zero unless WIN_A/WIN_B.
  - bit0 row 876, bit1 row 543, bit2 row 210
  - bit3 col 852, bit4 col 741, bit5 col 630
  - bit6 diag 840, bit7 diag 246
- `move_count`  out  4  accepted moves this game, 0..9.
- `move_ack`  out  1  one-cycle pulse: move accepted.
- `move_err`  out  1  one-cycle pulse: move rejected.

## Operation
- Reset state:
  - `ain` = `bin` = 0, `turn` = 0, `game_state` = PLAY, `win_line` = 0, `move_count` = 0, `move_ack` = `move_err` = 0.
  - Internal `first_player` register = 0 (A).
- Legal move, all required:
  - `game_state` = PLAY
  - `move_pos` has exactly one bit set
  - `(move_pos & (ain | bin)) == 0`
- Legal move, same edge:
  - OR `move_pos` into the mover's vector.
  - Toggle `turn`, increment `move_count`, pulse `move_ack`.
- Illegal move (any condition fails, including any move in WIN/DRAW): pulse `move_err`; board, turn, count and state unchanged.
- Win/draw evaluation, on the next-board value of the accepting edge:
  - Any line complete for the mover → WIN_A or WIN_B; `win_line` latches the detector output.
  - More than one line may complete on the final move (e.g. row plus diagonal); `win_line` then holds every completed bit.
  - Otherwise, if the next board is full (`ain|bin == 9'h1FF`) → DRAW.
  - A win on the 9th move takes priority over DRAW.
- WIN_A, WIN_B and DRAW are terminal until `new_game` or `rst`. Outputs hold.
- `new_game`:
  - Clears `ain`, `bin`, `win_line` and `move_count`; state returns to PLAY.
  - Toggles `first_player`; `turn` = new `first_player`.
  - Allowed in any state, including mid-game PLAY.
- Priority: `rst` > `new_game` > `move_valid`.
  - A `move_valid` in the same cycle as `new_game` or `rst` is dropped: no ack, no err.
- `rst` also returns `first_player` to A.

## Timing
- Move latency 1 cycle: the request sampled at edge N is reflected in all outputs after edge N.
- Back-to-back moves are accepted every cycle. No ready signal; the controller never stalls.
- `move_ack` and `move_err` are mutually exclusive and each high for exactly 1 cycle per request.
- `win_line` and `game_state` change on the same edge as the board. No extra cycle for detection.
- `move_count` saturates naturally at 9; any move after that is illegal.

## Structure
- Shared package holds:
  - game state encoding constants (PLAY, WIN_A, WIN_B, DRAW)
  - `FULL_BOARD` = 9'h1FF
  - `win_line` bit-index constants
- One natural sub-module: `line_win_detect`, combinational.
  - Inputs: 9-bit next-A and next-B boards. Output: 8-bit line vector.
  - Instantiated once, on the next-board values.
- Everything else (legality check, registers, state) lives in the top module.

## Test plan
- A win, row 210:
  - After reset play A:001, B:008, A:002, B:010, A:004.
  - Expect `ain` = 9'h007, `bin` = 9'h018, `win_line` = 8'h04, WIN_A, `move_count` = 5, `move_ack` 5 times.
- Illegal moves:
  - A:001, then B:001 → `move_err`, `bin` = 0, `turn` = 1.
  - Then B:003 (multi-hot) → `move_err`.
  - Then B:000 → `move_err`.
- Draw: play A0, B2, A1, B3, A5, B4, A6, B7, A8 (square indices).
  - Expect `ain` = 9'h163, `bin` = 9'h09C, DRAW, `win_line` = 0, `move_count` = 9.
  - A further move → `move_err`.
- Win on 9th move: play A1, B0, A5, B3, A2, B7, A4, B8, A6.
  - Expect `ain` = 9'h076, `bin` = 9'h189, WIN_A (not DRAW), `win_line` = 8'h80.
- `new_game` after the first test, with `move_valid` = 1 and `move_pos` = 9'h010 in the same cycle.
  - Expect board 0, PLAY, `turn` = 1 (B starts), no ack/err.
  - A second `new_game` → `turn` = 0.
- Reset mid-game: `rst` after 3 moves.
  - Expect all outputs at reset values and `first_player` = A.
  - The next A move is accepted.
